// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - control FSM sequencing fetch, operand staging, ALU wait and writeback
module instr_sequencer #(
    parameter int DATA_W    = 32,
    parameter int NUM_REGS  = 16,
    parameter int REG_SEL_W = 4,
    parameter int MAX_WAIT  = 64,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 run,
    input  logic                 mem_ready,
    input  logic                 alu_done,
    input  logic [DATA_W-1:0]    ir,
    output logic                 pc_out,
    output logic                 zlow_out,
    output logic                 zhigh_out,
    output logic                 mdr_out,
    output logic                 mar_in,
    output logic                 pc_in,
    output logic                 mdr_in,
    output logic                 ir_in,
    output logic                 y_in,
    output logic                 z_in,
    output logic                 hi_in,
    output logic                 lo_in,
    output logic                 inc_pc,
    output logic                 read,
    output logic                 alu_start,
    output logic [4:0]           alu_op,
    output logic [NUM_REGS-1:0]  reg_out_sel,
    output logic [NUM_REGS-1:0]  reg_in_sel,
    output logic                 busy,
    output logic                 halted,
    output logic                 err,
    output logic [CNT_W-1:0]     instr_count
);

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_MUL  = 5'b01110;
    localparam logic [4:0] OP_DIV  = 5'b01111;
    localparam logic [4:0] OP_HALT = 5'b11011;

    typedef enum logic [3:0] {
        S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALTED, S_ERR
    } state_t;

    state_t               state_q, state_d;
    logic [WAIT_W-1:0]    wait_q, wait_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [4:0]           op_q, op_d;
    logic [REG_SEL_W-1:0] ra_q, ra_d, rc_q, rc_d;

    logic [4:0]           ir_op;
    logic [REG_SEL_W-1:0] ir_ra, ir_rb, ir_rc;
    logic                 ir_legal, ir_halt, mul_div, ir_unused;

    assign ir_op     = ir[DATA_W-1 -: 5];
    assign ir_ra     = ir[DATA_W-6 -: REG_SEL_W];
    assign ir_rb     = ir[DATA_W-6-REG_SEL_W -: REG_SEL_W];
    assign ir_rc     = ir[DATA_W-6-2*REG_SEL_W -: REG_SEL_W];
    assign ir_unused = ^ir;
    assign ir_halt   = (ir_op == OP_HALT);
    assign ir_legal  = (ir_op == OP_ADD) || (ir_op == OP_SUB) || (ir_op == OP_AND) ||
                       (ir_op == OP_OR)  || (ir_op == OP_MUL) || (ir_op == OP_DIV);
    assign mul_div   = (op_q == OP_MUL) || (op_q == OP_DIV);

    always_comb begin
        state_d = state_q;
        wait_d  = '0;
        count_d = count_q;
        op_d    = op_q;
        ra_d    = ra_q;
        rc_d    = rc_q;
        case (state_q)
            S_IDLE: if (run) state_d = S_T0;
            S_T0:   state_d = S_T1;
            S_T1: begin
                // wait_q counts stall cycles already spent; one past MAX_WAIT is fatal
                if (mem_ready)                state_d = S_T2;
                else if (wait_q == WAIT_LIMIT) state_d = S_ERR;
                else                          wait_d  = wait_q + WAIT_W'(1);
            end
            S_T2:   state_d = S_T3;
            S_T3: begin
                op_d = ir_op;
                ra_d = ir_ra;
                rc_d = ir_rc;
                if (ir_halt)       state_d = S_HALTED;
                else if (ir_legal) state_d = S_T4;
                else               state_d = S_ERR;
            end
            S_T4:   state_d = S_T5;
            S_T5: begin
                if (alu_done)                 state_d = S_T6;
                else if (wait_q == WAIT_LIMIT) state_d = S_ERR;
                else                          wait_d  = wait_q + WAIT_W'(1);
            end
            S_T6: begin
                if (mul_div) begin
                    state_d = S_T7;
                end else begin
                    count_d = count_q + CNT_W'(1);
                    state_d = run ? S_T0 : S_IDLE;
                end
            end
            S_T7: begin
                count_d = count_q + CNT_W'(1);
                state_d = run ? S_T0 : S_IDLE;
            end
            default: state_d = state_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            wait_q  <= '0;
            count_q <= '0;
            op_q    <= '0;
            ra_q    <= '0;
            rc_q    <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            count_q <= count_d;
            op_q    <= op_d;
            ra_q    <= ra_d;
            rc_q    <= rc_d;
        end
    end

    // T3 reads Rb straight from ir because the IR is only loaded at the end of T2
    always_comb begin
        pc_out      = 1'b0;
        zlow_out    = 1'b0;
        zhigh_out   = 1'b0;
        mdr_out     = 1'b0;
        mar_in      = 1'b0;
        pc_in       = 1'b0;
        mdr_in      = 1'b0;
        ir_in       = 1'b0;
        y_in        = 1'b0;
        z_in        = 1'b0;
        hi_in       = 1'b0;
        lo_in       = 1'b0;
        inc_pc      = 1'b0;
        read        = 1'b0;
        alu_start   = 1'b0;
        reg_out_sel = '0;
        reg_in_sel  = '0;
        halted      = 1'b0;
        err         = 1'b0;
        busy        = 1'b1;
        case (state_q)
            S_IDLE: busy = 1'b0;
            S_T0: begin
                pc_out = 1'b1;
                mar_in = 1'b1;
                inc_pc = 1'b1;
                z_in   = 1'b1;
            end
            S_T1: begin
                zlow_out = 1'b1;
                pc_in    = (wait_q == '0);
                read     = 1'b1;
                mdr_in   = 1'b1;
            end
            S_T2: begin
                mdr_out = 1'b1;
                ir_in   = 1'b1;
            end
            S_T3: begin
                if (ir_legal) begin
                    reg_out_sel = NUM_REGS'(1) << ir_rb;
                    y_in        = 1'b1;
                end
            end
            S_T4: begin
                reg_out_sel = NUM_REGS'(1) << rc_q;
                alu_start   = 1'b1;
            end
            S_T5: begin
                reg_out_sel = NUM_REGS'(1) << rc_q;
                z_in        = alu_done;
            end
            S_T6: begin
                zlow_out = 1'b1;
                if (mul_div) lo_in      = 1'b1;
                else         reg_in_sel = NUM_REGS'(1) << ra_q;
            end
            S_T7: begin
                zhigh_out = 1'b1;
                hi_in     = 1'b1;
            end
            S_HALTED: begin
                busy   = 1'b0;
                halted = 1'b1;
            end
            default: begin
                busy = 1'b0;
                err  = 1'b1;
            end
        endcase
    end

    assign alu_op      = op_q;
    assign instr_count = count_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// tb/tb_instr_sequencer.sv - cycle table built from instruction-level rules, applied to instr_sequencer
module tb_instr_sequencer;

    localparam int MW = 64;
    localparam int P_IDLE = 0, P_T0 = 1, P_T1 = 2, P_T2 = 3, P_T3 = 4, P_T4 = 5;
    localparam int P_T5 = 6, P_T6 = 7, P_T7 = 8, P_HALT = 9, P_ERR = 10;

    localparam logic [14:0] M_PC_OUT = 15'h4000, M_ZLOW = 15'h2000, M_ZHIGH = 15'h1000;
    localparam logic [14:0] M_MDR_OUT = 15'h0800, M_MAR_IN = 15'h0400, M_PC_IN = 15'h0200;
    localparam logic [14:0] M_MDR_IN = 15'h0100, M_IR_IN = 15'h0080, M_Y_IN = 15'h0040;
    localparam logic [14:0] M_Z_IN = 15'h0020, M_HI_IN = 15'h0010, M_LO_IN = 15'h0008;
    localparam logic [14:0] M_INC_PC = 15'h0004, M_READ = 15'h0002, M_ALU_START = 15'h0001;

    typedef struct {
        bit          rst, run, mr, ad, chk, op_chk, busy, halted, err;
        logic [31:0] ir;
        logic [14:0] strb;
        logic [15:0] ros, ris;
        logic [4:0]  op;
        int          cnt;
        int          phase;
    } vec_t;

    logic clk = 1'b0, reset = 1'b1, run = 1'b0, mem_ready = 1'b0, alu_done = 1'b0;
    logic [31:0] ir = '0;
    logic pc_out, zlow_out, zhigh_out, mdr_out, mar_in, pc_in, mdr_in, ir_in, y_in, z_in;
    logic hi_in, lo_in, inc_pc, read, alu_start, busy, halted, err;
    logic [4:0]  alu_op;
    logic [15:0] reg_out_sel, reg_in_sel, instr_count;
    logic s_pc_out, s_zlow_out, s_zhigh_out, s_mdr_out, s_mar_in, s_pc_in, s_mdr_in, s_ir_in;
    logic s_y_in, s_z_in, s_hi_in, s_lo_in, s_inc_pc, s_read, s_alu_start, s_busy, s_halted, s_err;
    logic [4:0]  s_alu_op;
    logic [15:0] s_reg_out_sel, s_reg_in_sel;
    logic [2:0]  s_instr_count;

    always #5 clk = ~clk;

    instr_sequencer dut (
        .clk(clk), .reset(reset), .run(run), .mem_ready(mem_ready), .alu_done(alu_done), .ir(ir),
        .pc_out(pc_out), .zlow_out(zlow_out), .zhigh_out(zhigh_out), .mdr_out(mdr_out),
        .mar_in(mar_in), .pc_in(pc_in), .mdr_in(mdr_in), .ir_in(ir_in), .y_in(y_in), .z_in(z_in),
        .hi_in(hi_in), .lo_in(lo_in), .inc_pc(inc_pc), .read(read), .alu_start(alu_start),
        .alu_op(alu_op), .reg_out_sel(reg_out_sel), .reg_in_sel(reg_in_sel),
        .busy(busy), .halted(halted), .err(err), .instr_count(instr_count)
    );

    // narrow counter instance shares all stimulus so wrap-around is exercised many times
    instr_sequencer #(.CNT_W(3)) dut_s (
        .clk(clk), .reset(reset), .run(run), .mem_ready(mem_ready), .alu_done(alu_done), .ir(ir),
        .pc_out(s_pc_out), .zlow_out(s_zlow_out), .zhigh_out(s_zhigh_out), .mdr_out(s_mdr_out),
        .mar_in(s_mar_in), .pc_in(s_pc_in), .mdr_in(s_mdr_in), .ir_in(s_ir_in), .y_in(s_y_in),
        .z_in(s_z_in), .hi_in(s_hi_in), .lo_in(s_lo_in), .inc_pc(s_inc_pc), .read(s_read),
        .alu_start(s_alu_start), .alu_op(s_alu_op), .reg_out_sel(s_reg_out_sel),
        .reg_in_sel(s_reg_in_sel), .busy(s_busy), .halted(s_halted), .err(s_err),
        .instr_count(s_instr_count)
    );

    vec_t q[$];
    int   cnt = 0, cur = P_IDLE, lat_op = 0, lat_ra = 0, lat_rc = 0;
    int   n_checks = 0, n_fail = 0;

    function automatic bit rb();
        return ($urandom() % 2) == 1;
    endfunction

    function automatic logic [31:0] rir();
        return $urandom();
    endfunction

    function automatic bit is_legal(int op);
        return op == 3 || op == 4 || op == 5 || op == 6 || op == 14 || op == 15;
    endfunction

    function automatic vec_t mk(int ph, bit rstv, bit runv, bit mrv, bit adv, logic [31:0] irv, bit first);
        vec_t v;
        int   op;
        bit   mul;
        v = '{default: '0};
        v.rst = rstv; v.run = runv; v.mr = mrv; v.ad = adv; v.ir = irv;
        v.chk = 1'b1; v.phase = ph; v.cnt = cnt;
        v.busy = (ph >= P_T0) && (ph <= P_T7);
        mul = (lat_op == 14) || (lat_op == 15);
        case (ph)
            P_T0: v.strb = M_PC_OUT | M_MAR_IN | M_INC_PC | M_Z_IN;
            P_T1: v.strb = M_ZLOW | M_READ | M_MDR_IN | (first ? M_PC_IN : 15'h0);
            P_T2: v.strb = M_MDR_OUT | M_IR_IN;
            P_T3: begin
                op = int'((irv >> 27) & 32'h1F);
                if (is_legal(op)) begin
                    v.strb = M_Y_IN;
                    v.ros  = 16'h1 << ((irv >> 19) & 32'hF);
                end
            end
            P_T4: begin
                v.strb = M_ALU_START; v.ros = 16'h1 << lat_rc;
                v.op_chk = 1'b1; v.op = lat_op[4:0];
            end
            P_T5: begin
                v.strb = adv ? M_Z_IN : 15'h0; v.ros = 16'h1 << lat_rc;
                v.op_chk = 1'b1; v.op = lat_op[4:0];
            end
            P_T6: begin
                v.strb = M_ZLOW | (mul ? M_LO_IN : 15'h0);
                v.ris  = mul ? 16'h0 : (16'h1 << lat_ra);
            end
            P_T7: v.strb = M_ZHIGH | M_HI_IN;
            P_HALT: v.halted = 1'b1;
            P_ERR: v.err = 1'b1;
            default: ;
        endcase
        return v;
    endfunction

    task automatic cyc(int ph, bit rstv, bit runv, bit mrv, bit adv, logic [31:0] irv, bit first);
        q.push_back(mk(ph, rstv, runv, mrv, adv, irv, first));
    endtask

    task automatic do_reset();
        cyc(cur, 1'b1, rb(), rb(), rb(), rir(), 1'b0);
        cur = P_IDLE;
        cnt = 0;
    endtask

    task automatic sticky(int n);
        for (int i = 0; i < n; i++) cyc(cur, 1'b0, rb(), rb(), rb(), rir(), 1'b0);
    endtask

    // one instruction from T0: ms memory stalls, as ALU stalls, reset at the abort_at-th T5 cycle
    task automatic run_instr(logic [31:0] irv, int ms, int as, bit run_ret, int abort_at);
        int op;
        bit mul;
        cyc(P_T0, 1'b0, rb(), rb(), rb(), rir(), 1'b0);
        for (int k = 0; k <= ms; k++) begin
            if (k == MW + 1) begin cur = P_ERR; return; end
            cyc(P_T1, 1'b0, rb(), k == ms, rb(), rir(), k == 0);
        end
        cyc(P_T2, 1'b0, rb(), rb(), rb(), rir(), 1'b0);
        cyc(P_T3, 1'b0, rb(), rb(), rb(), irv, 1'b0);
        op     = int'((irv >> 27) & 32'h1F);
        lat_op = op;
        lat_ra = int'((irv >> 23) & 32'hF);
        lat_rc = int'((irv >> 15) & 32'hF);
        if (op == 27) begin cur = P_HALT; return; end
        if (!is_legal(op)) begin cur = P_ERR; return; end
        cyc(P_T4, 1'b0, rb(), rb(), rb(), rir(), 1'b0);
        for (int k = 0; k <= as; k++) begin
            if (k == MW + 1) begin cur = P_ERR; return; end
            if (k == abort_at) begin
                cyc(P_T5, 1'b1, rb(), rb(), 1'b0, rir(), 1'b0);
                cur = P_IDLE;
                cnt = 0;
                return;
            end
            cyc(P_T5, 1'b0, rb(), rb(), k == as, rir(), 1'b0);
        end
        mul = (op == 14) || (op == 15);
        cyc(P_T6, 1'b0, mul ? rb() : run_ret, rb(), rb(), rir(), 1'b0);
        if (mul) cyc(P_T7, 1'b0, run_ret, rb(), rb(), rir(), 1'b0);
        cnt++;
        cur = run_ret ? P_T0 : P_IDLE;
    endtask

    task automatic start_instr(logic [31:0] irv, int ms, int as, bit run_ret, int abort_at);
        if (cur == P_HALT || cur == P_ERR) begin
            sticky(int'($urandom_range(1, 3)));
            do_reset();
        end
        if (cur == P_IDLE) begin
            repeat ($urandom_range(0, 2)) cyc(P_IDLE, 1'b0, 1'b0, rb(), rb(), rir(), 1'b0);
            cyc(P_IDLE, 1'b0, 1'b1, rb(), rb(), rir(), 1'b0);
        end
        run_instr(irv, ms, as, run_ret, abort_at);
    endtask

    function automatic logic [31:0] rand_ir();
        int          roll, op;
        int          legal_ops[6] = '{3, 4, 5, 6, 14, 15};
        logic [31:0] opw;
        roll = int'($urandom_range(0, 19));
        if (roll == 0) op = 27;
        else if (roll == 1) begin
            op = int'($urandom_range(0, 31));
            while (is_legal(op) || op == 27) op = int'($urandom_range(0, 31));
        end else op = legal_ops[$urandom_range(0, 5)];
        opw = op;
        return (opw << 27) | ($urandom() & 32'h07FF_FFFF);
    endfunction

    task automatic check(string name, int row, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s row=%0d phase=%0d actual=0x%0h expected=0x%0h", name, row, q[row].phase, act, exp);
        end
    endtask

    task automatic check_row(int i);
        logic [14:0] a;
        int          drv;
        a = {pc_out, zlow_out, zhigh_out, mdr_out, mar_in, pc_in, mdr_in, ir_in,
             y_in, z_in, hi_in, lo_in, inc_pc, read, alu_start};
        drv = int'(pc_out) + int'(zlow_out) + int'(zhigh_out) + int'(mdr_out) + $countones(reg_out_sel);
        check("strobes", i, a, q[i].strb);
        check("reg_out_sel", i, reg_out_sel, q[i].ros);
        check("reg_in_sel", i, reg_in_sel, q[i].ris);
        check("busy_halted_err", i, {busy, halted, err}, {q[i].busy, q[i].halted, q[i].err});
        check("instr_count", i, instr_count, q[i].cnt & 32'hFFFF);
        check("instr_count_w3", i, s_instr_count, q[i].cnt & 32'h7);
        check("bus_drivers_le1", i, drv <= 1, 1);
        if (q[i].op_chk) check("alu_op", i, alu_op, q[i].op);
    endtask

    initial begin
        vec_t v0;
        v0 = '{default: '0};
        v0.rst = 1'b1;
        q.push_back(v0);
        cyc(P_IDLE, 1'b0, 1'b0, 1'b1, 1'b1, rir(), 1'b0);
        cyc(P_IDLE, 1'b0, 1'b0, 1'b0, 1'b1, rir(), 1'b0);

        start_instr(32'h1894_8000, 0, 0, 1'b0, -1);
        cyc(P_IDLE, 1'b0, 1'b0, rb(), rb(), rir(), 1'b0);
        start_instr(32'h7A92_0000, 0, 32, 1'b1, -1);
        start_instr(32'h2123_8000, MW, MW, 1'b1, -1);
        start_instr(32'h1894_8000, MW + 1, 0, 1'b1, -1);
        sticky(6);
        start_instr(32'h3000_0000, 2, MW + 1, 1'b1, -1);
        sticky(3);
        start_instr(32'hD800_0000, 1, 0, 1'b1, -1);
        sticky(8);
        start_instr(32'hF800_0000, 0, 0, 1'b1, -1);
        sticky(3);
        start_instr(32'h7012_3456, 1, 10, 1'b1, 3);
        cyc(P_IDLE, 1'b0, 1'b0, rb(), rb(), rir(), 1'b0);
        start_instr(32'h1894_8000, 0, 0, 1'b0, -1);

        for (int n = 0; n < 150; n++) begin
            int ms, as, ab;
            ms = ($urandom_range(0, 11) == 0) ? int'($urandom_range(MW - 1, MW + 1)) : int'($urandom_range(0, 3));
            as = ($urandom_range(0, 11) == 0) ? int'($urandom_range(MW - 1, MW + 1)) : int'($urandom_range(0, 3));
            ab = ($urandom_range(0, 24) == 0) ? int'($urandom_range(0, 2)) : -1;
            start_instr(rand_ir(), ms, as, rb(), ab);
        end
        do_reset();
        cyc(P_IDLE, 1'b0, 1'b0, rb(), rb(), rir(), 1'b0);

        for (int i = 0; i < q.size(); i++) begin
            @(posedge clk);
            #1;
            reset     = q[i].rst;
            run       = q[i].run;
            mem_ready = q[i].mr;
            alu_done  = q[i].ad;
            ir        = q[i].ir;
            @(negedge clk);
            if (q[i].chk) check_row(i);
        end
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
